io_input_port: RTL and testbench
================================

# io_input_port

Input-side peripheral for the processor's I/O subsystem: it owns the 18 board switches and the active-low confirm key. It synchronizes both, debounces the key, and completes the processor's input instruction with a request/done handshake. While the instruction waits for a confirmed value, the block stalls the PC. It then presents the switch word zero-extended to 32 bits, which the register-file write mux consumes.

## Interface
- DATA_W, 18, switch word width (≤ 32)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced key level changes (≥ 2)
- clock  in  1  system clock (processor clock domain)
- reset  in  1  asynchronous, active-low reset
- sw  in  DATA_W  raw switch levels, asynchronous to clock
- confirm  in  1  raw confirm key, active-low (0 = pressed), asynchronous, bouncing
- read_req  in  1  level from control decode; high while an input instruction is in execution
- stall  out  1  combinational; high when read_req=1 and done=0; ORed into the PC halt
- done  out  1  registered one-cycle pulse; the instruction completes this cycle
- data_out  out  32  registered {zeros, captured sw}; holds the last captured value

## Operation
- Synchronizers: two flops on confirm and on every sw bit; sync outputs reset to confirm=1, sw=0.
- Debounce: counter increments on each edge where sync confirm ≠ debounced level, and clears otherwise. When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears. Debounced level resets to 1 (released).
- Press event: debounced level transitions 1→0; valid for the single cycle after the toggle.
- FSM states:
  - IDLE
    - read_req=1 → WAIT.
  - WAIT
    - read_req=0 → IDLE (abort; no done, data_out unchanged).
    - Press event → DONE; data_out ← sync sw at the same edge.
  - DONE
    - done=1 for this one cycle.
    - Next state is RELEASE.
  - RELEASE
    - Debounced level 1 → WAIT if read_req=1, else IDLE.
    - Otherwise stay (a held key never satisfies two reads).
- Press events in IDLE or RELEASE are discarded; there is no buffering.
- Switches are not debounced; the user sets them before pressing.
- Reset values: state IDLE, done=0, data_out=0, counter=0, debounced=1. stall follows read_req (combinational).
- Asynchronous reset assertion mid-WAIT or mid-DONE returns everything to reset values immediately. A done pulse in flight is lost.

## Timing
- Raw confirm falling edge first sampled at edge E0; sync output low after E1. At edge E1+DEBOUNCE_CYCLES the debounced level falls. At edge E2+DEBOUNCE_CYCLES, done=1 and data_out is updated, provided the FSM is in WAIT. Total: DEBOUNCE_CYCLES+2 edges after first sampling, for a clean press.
- Any bounce back to 1 before the count completes restarts the count.
- read_req sampled in IDLE: WAIT from the next edge; stall is already high in the same cycle.
- stall falls in the done cycle, so the processor advances on the edge that ends DONE.
- Release detection takes DEBOUNCE_CYCLES+2 edges, mirroring the press path.
- data_out is stable from the done cycle until the next capture. It is safe to read combinationally in the done cycle.

## Structure
- Shared I/O package: state encoding (IDLE, WAIT, DONE, RELEASE, 2 bits), the DATA_W default, and the 32-bit word width constant shared with the output ports.
- One sub-module, key_debouncer: synchronizer, counter, debounced level and press/release event outputs. It is reusable for the reset and continue keys. The FSM and capture register stay in io_input_port.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset mid-operation: assert reset during WAIT → state IDLE, done=0 and data_out=0 immediately. After release, read_req=1 stalls until a fresh press.
- Clean read: sw=0x2A5F3, read_req=1, confirm low held → stall=1 until done. done is exactly one cycle, 6 edges after first sampling; data_out=0x0002A5F3; stall=0 in the done cycle.
- Bounce rejection: confirm toggles low/high every 2 cycles for 20 cycles, then stays low → no done during bouncing; exactly one done, 6 edges after the final stable low.
- Held key across two reads: first read completes, read_req re-asserted while the key is still held → no second done. After release, a new press yields done with the new sw value (e.g. 0x00001).
- Idle press discarded and abort: press while read_req=0 → no done, data_out unchanged. Then read_req=1 for 3 cycles and drop → state IDLE, no done.
- Full-width value: sw=0x3FFFF → data_out=0x0003FFFF; upper 14 bits stay 0.

Source files
------------

// File: rtl/io_input_port_pkg.sv
// Shared I/O subsystem definitions: input-port FSM encoding and the word widths
// shared with the processor-facing output ports.
package io_input_port_pkg;

    localparam int DATA_W_DEFAULT = 18;
    localparam int WORD_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } ioState_t;

endpackage

// File: rtl/io_input_port_key_debouncer.sv
// Two-flop synchronizer and stable-count debouncer for an active-low key.
// Emits one-cycle press (1->0) and release (0->1) events on the debounced level.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic keyRaw,
    output logic pressEvent,
    output logic releaseEvent
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             keyMeta;
    logic             keySync;
    logic             keyLevel;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            keyMeta      <= 1'b1;
            keySync      <= 1'b1;
            keyLevel     <= 1'b1;
            count        <= '0;
            pressEvent   <= 1'b0;
            releaseEvent <= 1'b0;
        end else begin
            keyMeta      <= keyRaw;
            keySync      <= keyMeta;
            pressEvent   <= 1'b0;
            releaseEvent <= 1'b0;
            // Any sample matching the current level restarts the stability count.
            if (keySync != keyLevel) begin
                if (count == CNT_LAST) begin
                    keyLevel     <= keySync;
                    count        <= '0;
                    pressEvent   <= ~keySync;
                    releaseEvent <= keySync;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/io_input_port.sv
// Processor input port: stalls the PC during an input instruction until a debounced
// confirm press, then captures the synchronized switch word and pulses done.
//
// state      | meaning
// ST_IDLE    | no input instruction pending
// ST_WAIT    | instruction pending, waiting for a confirm press
// ST_DONE    | value captured, done pulse this cycle
// ST_RELEASE | waiting for key release so a held key cannot satisfy a second read
module io_input_port
    import io_input_port_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw,
    input  logic              confirm,
    input  logic              read_req,
    output logic              stall,
    output logic              done,
    output logic [WORD_W-1:0] data_out
);

    logic [DATA_W-1:0] swMeta;
    logic [DATA_W-1:0] swSync;
    logic              pressEvent;
    logic              releaseEvent;
    ioState_t          state;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uConfirm (
        .clock       (clock),
        .reset       (reset),
        .keyRaw      (confirm),
        .pressEvent  (pressEvent),
        .releaseEvent(releaseEvent)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            swMeta <= '0;
            swSync <= '0;
        end else begin
            swMeta <= sw;
            swSync <= swMeta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (read_req) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!read_req) begin
                        state <= ST_IDLE;
                    end else if (pressEvent) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        data_out <= WORD_W'(swSync);
                    end
                end
                ST_DONE: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (releaseEvent) state <= read_req ? ST_WAIT : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Drops in the done cycle so the PC advances on the edge that ends DONE.
    assign stall = read_req & ~done;

endmodule

// File: tb/tb_io_input_port.sv
// Randomized scoreboard bench for io_input_port: stimulus pushes expected captures
// with their expected cycle, a negedge monitor checks done, stall and data_out.
module tb_io_input_port;

    localparam int DW  = 18;
    localparam int DB  = 4;
    localparam int LAT = DB + 3;   // input drive to done cycle for a clean press

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic [DW-1:0] sw       = '0;
    logic          confirm  = 1'b1;
    logic          read_req = 1'b0;
    logic          stall;
    logic          done;
    logic [31:0]   data_out;

    int          cyc      = 0;
    int          total    = 0;
    int          passed   = 0;
    logic [31:0] lastData = '0;
    logic        expDone;
    exp_t        cur;
    exp_t        sbQ[$];

    io_input_port #(
        .DATA_W         (DW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .sw      (sw),
        .confirm (confirm),
        .read_req(read_req),
        .stall   (stall),
        .done    (done),
        .data_out(data_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    always @(negedge clock) begin
        if (!reset) lastData = '0;
        expDone = (sbQ.size() > 0) && (sbQ[0].cyc == cyc);
        check("done", 32'(done), 32'(expDone));
        check("stall", 32'(stall), 32'(read_req & ~expDone));
        if (expDone) begin
            cur = sbQ.pop_front();
            check("data_out", data_out, 32'(cur.data));
            lastData = 32'(cur.data);
        end else begin
            if (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
                total++;
                $display("FAIL done_missing: no done by cycle %0d expected at %0d", cyc, sbQ[0].cyc);
                void'(sbQ.pop_front());
            end
            check("data_hold", data_out, lastData);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic waitDone();
        int n = 0;
        while (sbQ.size() > 0 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic pressAndExpect(input logic [DW-1:0] val);
        sw      = val;
        confirm = 1'b0;
        sbQ.push_back('{data: val, cyc: cyc + LAT});
        waitDone();
    endtask

    task automatic releaseKey();
        confirm = 1'b1;
        repeat (12) tick();
    endtask

    task automatic bounceRandom();
        int n = $urandom_range(3, 6);
        for (int i = 0; i < n; i++) begin
            confirm = 1'b0;
            repeat ($urandom_range(1, DB - 1)) tick();
            confirm = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic doRead(input logic [DW-1:0] val, input bit bounce);
        read_req = 1'b1;
        tick();
        tick();
        if (bounce) bounceRandom();
        pressAndExpect(val);
        read_req = 1'b0;
        releaseKey();
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        // clean read
        doRead(18'h2A5F3, 1'b0);

        // fixed bounce: low/high every 2 cycles, then stable low
        read_req = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            confirm = 1'b0;
            repeat (2) tick();
            confirm = 1'b1;
            repeat (2) tick();
        end
        pressAndExpect(18'h0BEEF);
        read_req = 1'b0;
        releaseKey();

        // held key across two reads
        read_req = 1'b1;
        repeat (2) tick();
        pressAndExpect(18'h15555);
        read_req = 1'b0;
        repeat (2) tick();
        read_req = 1'b1;
        repeat (15) tick();
        confirm = 1'b1;
        repeat (12) tick();
        pressAndExpect(18'h00001);
        read_req = 1'b0;
        releaseKey();

        // press while idle is discarded, then aborted read
        sw      = DW'($urandom_range(0, (1 << DW) - 1));
        confirm = 1'b0;
        repeat (10) tick();
        confirm = 1'b1;
        repeat (12) tick();
        read_req = 1'b1;
        repeat (3) tick();
        read_req = 1'b0;
        repeat (4) tick();

        // full width
        doRead(18'h3FFFF, 1'b0);

        // randomized reads with random bounce prefixes
        for (int i = 0; i < 6; i++) begin
            doRead(DW'($urandom_range(0, (1 << DW) - 1)), bit'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of WAIT with a press in progress
        read_req = 1'b1;
        repeat (2) tick();
        sw      = 18'h12345;
        confirm = 1'b0;
        repeat (3) tick();
        #1 reset = 1'b0;
        confirm = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (10) tick();
        pressAndExpect(18'h2C0DE);
        read_req = 1'b0;
        releaseKey();

        repeat (10) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
